ddr_wr_buf: RTL and testbench

//   Pixel-to-DDR write buffer directly upstream of the DDR write controller.
//   - Packs a 32-bit pixel stream into 256-bit words, 8 pixels per word.
//   - Queues the words in a first-word-fall-through (FWFT) FIFO.
//   - Starts one write burst (wr_start) each time a full burst of words is buffered.
//   - Serves the controller's per-beat data_req pops, with the word on wr_ddr_data.

---
 rtl/ddr_wr_buf.sv | 135 +++++++++++++
 tb/tb_ddr_wr_buf.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_buf.sv
// Pixel-to-DDR write buffer: packs pixels into DDR words, queues them in a
// first-word-fall-through FIFO and launches one write burst per buffered burst.
module ddr_wr_buf #(
    parameter int PIX_W      = 32,
    parameter int WORD_W     = 256,
    parameter int FIFO_DEPTH = 128,
    parameter int BURST_LEN  = 64
) (
    input  logic                          ui_clk,
    input  logic                          rst,
    input  logic                          pix_vld,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          pix_sof,
    output logic                          wr_start,
    input  logic                          wr_done,
    input  logic                          data_req,
    output logic [WORD_W-1:0]             wr_ddr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    output logic                          udf
);
    localparam int LANES  = WORD_W / PIX_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    logic [LANE_W-1:0] lane_q, lane_cur;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_push;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full, empty, push_ok, pop_ok;
    logic              ovf_q, udf_q;

    state_t            state_q, state_d;
    logic              wr_start_q;

    // A start-of-frame pixel restarts the word at lane 0; stale upper lanes
    // are always overwritten before the word can complete.
    assign lane_cur  = pix_sof ? '0 : lane_q;
    assign word_push = pix_vld && (lane_cur == LANE_W'(LANES - 1));

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign word_d[gi*PIX_W +: PIX_W] =
                (lane_cur == LANE_W'(gi)) ? pix_data : word_q[gi*PIX_W +: PIX_W];
        end
    endgenerate

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            lane_q <= '0;
        end else if (pix_vld) begin
            lane_q <= lane_cur + 1'b1;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (pix_vld) begin
            word_q <= word_d;
        end
    end

    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = data_req && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = word_push && (!full || pop_ok);

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= word_d;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            if (word_push && !push_ok) ovf_q <= 1'b1;
            if (data_req && empty)     udf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (level_q >= LVL_W'(BURST_LEN)) state_d = START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (wr_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_start_q <= (state_d == START);
        end
    end

    assign wr_start    = wr_start_q;
    assign wr_ddr_data = mem_q[rd_ptr_q];
    assign fifo_level  = level_q;
    assign ovf         = ovf_q;
    assign udf         = udf_q;

endmodule

// File: tb/tb_ddr_wr_buf.sv
// Bench for ddr_wr_buf: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model.
module tb_ddr_wr_buf;
    logic         ui_clk = 1'b0;
    logic         rst = 1'b0;
    logic         pix_vld = 1'b0;
    logic [31:0]  pix_data = '0;
    logic         pix_sof = 1'b0;
    logic         wr_start;
    logic         wr_done = 1'b0;
    logic         data_req = 1'b0;
    logic [255:0] wr_ddr_data;
    logic [7:0]   fifo_level;
    logic         ovf;
    logic         udf;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;

    logic [255:0] m_q[$];
    logic [31:0]  m_pix[$];
    bit           m_ovf, m_udf, m_busy, m_start;

    always #5 ui_clk = ~ui_clk;

    ddr_wr_buf dut (
        .ui_clk      (ui_clk),
        .rst         (rst),
        .pix_vld     (pix_vld),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .wr_start    (wr_start),
        .wr_done     (wr_done),
        .data_req    (data_req),
        .wr_ddr_data (wr_ddr_data),
        .fifo_level  (fifo_level),
        .ovf         (ovf),
        .udf         (udf)
    );

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle, advance the reference model across the edge, then compare.
    task automatic step(input logic vld, input logic [31:0] d, input logic sof,
                        input logic req, input logic done, input logic r);
        int           lvl_pre;
        bit           prev_start;
        logic [255:0] w;
        rst = r; pix_vld = vld; pix_data = d; pix_sof = sof;
        data_req = req; wr_done = done;
        if (r) begin
            m_q.delete(); m_pix.delete();
            m_ovf = 0; m_udf = 0; m_busy = 0; m_start = 0;
        end else begin
            lvl_pre    = m_q.size();
            prev_start = m_start;
            m_start    = 0;
            if (!m_busy) begin
                if (lvl_pre >= 64) begin
                    m_busy  = 1;
                    m_start = 1;
                end
            end else if (!prev_start && done) begin
                m_busy = 0;
            end
            if (req) begin
                if (m_q.size() > 0) w = m_q.pop_front();
                else m_udf = 1;
            end
            if (vld) begin
                if (sof) m_pix.delete();
                m_pix.push_back(d);
                if (m_pix.size() == 8) begin
                    w = '0;
                    for (int k = 0; k < 8; k++) w[32*k +: 32] = m_pix[k];
                    m_pix.delete();
                    if (m_q.size() < 128) m_q.push_back(w);
                    else m_ovf = 1;
                end
            end
        end
        @(posedge ui_clk);
        #1;
        chk("level", 256'(fifo_level), 256'(m_q.size()));
        chk("ovf", 256'(ovf), 256'(m_ovf));
        chk("udf", 256'(udf), 256'(m_udf));
        chk("wr_start", 256'(wr_start), 256'(m_start));
        if (m_q.size() > 0) chk("head", wr_ddr_data, m_q[0]);
        if (wr_start) start_cnt++;
    endtask

    initial begin
        logic [255:0] w;
        int           reqw[4];
        reqw = '{0, 1, 6, 12};

        // T1: reset while a pixel is offered
        step(1, 32'hDEAD_BEEF, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // T2: one full burst of pixels
        start_cnt = 0;
        for (int i = 0; i < 512; i++) step(1, 32'(i), (i == 0), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) w[32*k +: 32] = 32'(k);
        chk("t2_head", wr_ddr_data, w);
        chk("t2_starts", 256'(start_cnt), 256'(1));

        // T3: drain the burst, then close it; level below a burst must not relaunch
        for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
        chk("t3_starts", 256'(start_cnt), 256'(1));

        // T4: start-of-frame discards a partial word
        step(1, 32'hA, 0, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0, 0);
        step(1, 32'hC, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 32'(100 + i), (i == 0), 0, 0, 0);
        for (int k = 0; k < 8; k++) w[32*k +: 32] = 32'(100 + k);
        chk("t4_word", wr_ddr_data, w);
        chk("t4_level", 256'(fifo_level), 256'(1));
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);

        // T5: overflow drops the 129th word
        for (int i = 0; i < 1032; i++) step(1, 32'(i), (i == 0), 0, 0, 0);
        chk("t5_ovf", 256'(ovf), 256'(1));
        for (int i = 0; i < 128; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // T6: underflow, then simultaneous push and pop at level 5
        step(1, 32'hFFFF_0000, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        chk("t6_udf", 256'(udf), 256'(1));
        for (int i = 0; i < 40; i++) step(1, 32'(i), (i == 0), 0, 0, 0);
        for (int i = 40; i < 47; i++) step(1, 32'(i), 0, 0, 0, 0);
        step(1, 32'd47, 0, 1, 0, 0);
        chk("t6_level", 256'(fifo_level), 256'(5));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);

        // Randomized traffic with varying pop pressure and occasional resets
        step(0, 0, 0, 0, 0, 1);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 1500; i++) begin
                step(($urandom % 4) != 0, $urandom, ($urandom % 64) == 0,
                     ($urandom % 16) < reqw[p], ($urandom % 40) == 0,
                     ($urandom % 700) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
